counter_ud_mc: RTL and testbench
================================

# counter_ud_mc

Parametrised multi-channel up/down counter bank with per-channel load, programmable terminal limit, and a wrap or saturate mode per channel. Each channel also provides a terminal-count flag, a registered wrap/saturate event pulse, and a sticky overflow status with explicit clear. The block replaces single-channel free-running counters wherever a design needs several independently controlled counters with bounded range, such as timers, credit counters or pointer generators. All channels share one clock and one reset and are otherwise fully independent.

## Interface

- `WIDTH`, default 4: counter width per channel, ≥1.
- `NUM_CH`, default 4: number of channels, ≥1.
- Packed buses use channel c at bits `[c*WIDTH +: WIDTH]`; 1-bit-per-channel vectors use bit c.

Ports:

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  NUM_CH  count enable per channel.
- `load_en`  in  NUM_CH  synchronous load strobe per channel.
- `load`  in  NUM_CH*WIDTH  load values.
- `down`  in  NUM_CH  direction: 1 = decrement, 0 = increment.
- `limit`  in  NUM_CH*WIDTH  per-channel upper bound; channel range is 0..limit inclusive.
- `sat_mode`  in  NUM_CH  1 = saturate at bounds, 0 = wrap.
- `ovf_clr`  in  NUM_CH  clears `ovf_sticky` for the channel.
- `count`  out  NUM_CH*WIDTH  registered counter values.
- `tc`  out  NUM_CH  combinational terminal count: `down ? count==0 : count>=limit`.
- `evt`  out  NUM_CH  registered one-cycle pulse: a wrap or saturation occurred on the last edge.
- `ovf_sticky`  out  NUM_CH  registered sticky event flag.

## Operation

Each channel applies the following rules on every rising edge of `clk`. Priority is strictly `rst` > `load_en` > `en`.

- **Reset** (`rst`=1): `count`=0, `evt`=0, `ovf_sticky`=0 for all channels.
- **Load** (`load_en`=1):
  - `count` takes `min(load, limit)`.
  - `evt`=0, and `en` and `down` are ignored.
  - A load never sets `ovf_sticky`.
- **Count up** (`en`=1, `down`=0):
  - If `count < limit`, the next value is `count+1`.
  - If `count >= limit`, an event occurs. The next value is 0 in wrap mode and `limit` in saturate mode.
- **Count down** (`en`=1, `down`=1):
  - If `count > 0`, the next value is `count-1`. If `count > limit` (because `limit` was lowered), the next value is `limit` and no event occurs.
  - If `count == 0`, an event occurs. The next value is `limit` in wrap mode and 0 in saturate mode.
- **Idle** (`en`=0 and no load): `count` holds and `evt`=0.
- **Event flags**:
  - `evt` is 1 for exactly the cycle following an event edge.
  - `ovf_sticky` is set on an event. When an event and `ovf_clr` coincide, the set wins.
  - `ovf_clr` with no event clears the flag.
  - `ovf_clr` has no effect on `count` or `evt`.
- **Arithmetic**:
  - All compares are unsigned, WIDTH bits.
  - The next-count logic never produces a value outside 0..limit, except when a lowered `limit` leaves `count` out of range while the channel is idle.
- **`limit`=0**: `count` stays 0. Every enabled step is an event in both modes.
- **`sat_mode`, `limit`, `down`**: these are sampled every cycle, so changing them mid-count takes effect on the next edge.
- **Channel independence**: no cross-channel interaction.

## Timing

- `count`, `evt` and `ovf_sticky` are registered. `tc` is combinational from `count`, `limit` and `down`, with no input-to-output path that bypasses `count` other than through `limit` and `down`.
- **Latency**:
  - A load or step is visible on `count` one cycle after the sampling edge.
  - `evt` rises on the same edge that produces the wrapped or saturated value.
  - `ovf_sticky` rises on that same edge.
- **Reset**:
  - Reset takes effect on the first edge with `rst`=1. Asserting it mid-count discards the step in flight.
  - On the first edge after `rst` deasserts, the inputs are honoured normally.
- **Throughput**: one step per cycle per channel, back-to-back, with no bubbles.

## Test plan

- **Reset**: hold `rst` for 3 cycles with `en`=all 1s → `count`=0, `evt`=0 and `ovf_sticky`=0 throughout. Then release with WIDTH=4, `limit`=15 and up → `count` reads 1, 2, 3 on successive cycles.
- **Wrap up**: ch0 with `limit`=5, `sat_mode`=0, up, enabled from 0 → `count` runs 0,1,2,3,4,5,0. `tc`=1 while `count`=5. `evt`=1 only in the cycle `count`=0 reappears. `ovf_sticky` stays 1.
- **Saturate down and clear**: ch1 with `limit`=9, `sat_mode`=1, down, loaded with 2 → `count` runs 2,1,0,0,0. `evt` pulses in every cycle after an enabled step at 0. `ovf_clr` on a held cycle with `en`=0 → `ovf_sticky` goes 0. `ovf_clr` together with an event → `ovf_sticky` stays 1.
- **Load priority and clamp**: ch2 with `limit`=7 and `load_en`=1, `en`=1, `load`=12 → `count`=7 and `evt`=0. Next cycle `load_en`=0, up, wrap → `count`=0 and `evt`=1.
- **Lowered limit and `limit`=0**:
  - ch3 at `count`=10, then `limit` changed to 4 with down → `count`=4, no event.
  - Then up → `count`=0 (wrap) with an event.
  - Set `limit`=0 with `en`=1 → `count` stays 0 and `evt`=1 every cycle.
- **Independence**: random `en`/`down`/`load_en`/`load`/`limit`/`sat_mode` on all 4 channels for 1000 cycles, compared against a reference model → all channels match every cycle, with a mid-run `rst` pulse zeroing all state.

Source files
------------

// File: rtl/counter_ud_mc.sv
// counter_ud_mc: bank of NUM_CH independent up/down counters sharing one clock and
// one synchronous active-high reset.
//
// Each channel counts within 0..limit (inclusive). At a bound it either wraps or
// saturates, as selected by sat_mode. A load strobe overrides counting, and the
// loaded value is clamped to limit.
//
// Ports (channel c uses bit c, or bits [c*WIDTH +: WIDTH] on packed buses):
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   count enable per channel
//   load_en    in   load strobe per channel (wins over en)
//   load       in   load values
//   down       in   1 = decrement, 0 = increment
//   limit      in   upper bound per channel
//   sat_mode   in   1 = saturate at bounds, 0 = wrap
//   ovf_clr    in   clears ovf_sticky (a coincident event wins)
//   count      out  registered counter values
//   tc         out  terminal count: down ? count == 0 : count >= limit
//   evt        out  registered one-cycle pulse after a wrap/saturate edge
//   ovf_sticky out  registered sticky event flag
module counter_ud_mc #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned NUM_CH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       load_en,
    input  logic [NUM_CH*WIDTH-1:0] load,
    input  logic [NUM_CH-1:0]       down,
    input  logic [NUM_CH*WIDTH-1:0] limit,
    input  logic [NUM_CH-1:0]       sat_mode,
    input  logic [NUM_CH-1:0]       ovf_clr,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       tc,
    output logic [NUM_CH-1:0]       evt,
    output logic [NUM_CH-1:0]       ovf_sticky
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [WIDTH-1:0] lim;
        logic [WIDTH-1:0] ld;
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] cnt_d;
        logic             evt_q;
        logic             evt_d;
        logic             ovf_q;
        logic             ovf_d;

        assign lim = limit[c*WIDTH +: WIDTH];
        assign ld  = load[c*WIDTH +: WIDTH];

        always_comb begin
            cnt_d = cnt_q;
            evt_d = 1'b0;
            if (load_en[c]) begin
                cnt_d = (ld > lim) ? lim : ld;
            end else if (en[c]) begin
                if (!down[c]) begin
                    if (cnt_q < lim) begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end else begin
                        // At or above the bound: also catches a count stranded above
                        // a lowered limit, which is pulled back into range.
                        evt_d = 1'b1;
                        cnt_d = sat_mode[c] ? lim : '0;
                    end
                end else begin
                    if (cnt_q == '0) begin
                        evt_d = 1'b1;
                        cnt_d = sat_mode[c] ? '0 : lim;
                    end else if (cnt_q > lim) begin
                        // Limit was lowered under us: snap to it without an event.
                        cnt_d = lim;
                    end else begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end
                end
            end
            // Set beats clear when both happen on the same edge.
            if (evt_d) begin
                ovf_d = 1'b1;
            end else if (ovf_clr[c]) begin
                ovf_d = 1'b0;
            end else begin
                ovf_d = ovf_q;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
                evt_q <= 1'b0;
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                evt_q <= evt_d;
                ovf_q <= ovf_d;
            end
        end

        assign count[c*WIDTH +: WIDTH] = cnt_q;
        assign evt[c]                  = evt_q;
        assign ovf_sticky[c]           = ovf_q;
        assign tc[c]                   = down[c] ? (cnt_q == '0) : (cnt_q >= lim);
    end

endmodule

// File: tb/tb_counter_ud_mc.sv
module tb_counter_ud_mc;
    localparam int W   = 4;
    localparam int NCH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   en, load_en, down, sat_mode, ovf_clr;
    logic [NCH*W-1:0] load, limit;
    logic [NCH*W-1:0] count;
    logic [NCH-1:0]   tc, evt, ovf_sticky;

    counter_ud_mc #(.WIDTH(W), .NUM_CH(NCH)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load_en    (load_en),
        .load       (load),
        .down       (down),
        .limit      (limit),
        .sat_mode   (sat_mode),
        .ovf_clr    (ovf_clr),
        .count      (count),
        .tc         (tc),
        .evt        (evt),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [NCH-1:0]   mask;
        logic [NCH*W-1:0] cnt;
        logic [NCH-1:0]   evt;
        logic [NCH-1:0]   ovf;
        logic [NCH-1:0]   tc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Monitor: one expectation per cycle, sampled just after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int c = 0; c < NCH; c++) begin
                    if (e.mask[c]) begin
                        checks += 4;
                        if (count[c*W +: W] !== e.cnt[c*W +: W]) begin
                            errors++;
                            $display("FAIL %s ch%0d count got=%0d exp=%0d", e.name, c,
                                     count[c*W +: W], e.cnt[c*W +: W]);
                        end
                        if (evt[c] !== e.evt[c]) begin
                            errors++;
                            $display("FAIL %s ch%0d evt got=%b exp=%b", e.name, c, evt[c],
                                     e.evt[c]);
                        end
                        if (ovf_sticky[c] !== e.ovf[c]) begin
                            errors++;
                            $display("FAIL %s ch%0d ovf got=%b exp=%b", e.name, c,
                                     ovf_sticky[c], e.ovf[c]);
                        end
                        if (tc[c] !== e.tc[c]) begin
                            errors++;
                            $display("FAIL %s ch%0d tc got=%b exp=%b", e.name, c, tc[c],
                                     e.tc[c]);
                        end
                    end
                end
            end
        end
    end

    // Push expectation for the coming edge, then move to the next falling edge.
    task automatic push_tick(input exp_t e);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic tick_ch(input string name, input int c, input logic [W-1:0] cv,
                           input logic ev, input logic ov, input logic tv);
        exp_t e;
        e.name = name;
        e.mask = '0;
        e.cnt  = '0;
        e.evt  = '0;
        e.ovf  = '0;
        e.tc   = '0;
        e.mask[c]        = 1'b1;
        e.cnt[c*W +: W]  = cv;
        e.evt[c]         = ev;
        e.ovf[c]         = ov;
        e.tc[c]          = tv;
        push_tick(e);
    endtask

    task automatic tick_all(input string name, input logic [W-1:0] cv);
        exp_t e;
        e.name = name;
        e.mask = '1;
        for (int c = 0; c < NCH; c++) e.cnt[c*W +: W] = cv;
        e.evt = '0;
        e.ovf = '0;
        e.tc  = '0;
        push_tick(e);
    endtask

    task automatic set_ch(input int c, input logic e_v, input logic l_v, input logic [W-1:0] ld,
                          input logic d_v, input logic [W-1:0] lim, input logic s_v,
                          input logic clr);
        en[c]             = e_v;
        load_en[c]        = l_v;
        load[c*W +: W]    = ld;
        down[c]           = d_v;
        limit[c*W +: W]   = lim;
        sat_mode[c]       = s_v;
        ovf_clr[c]        = clr;
    endtask

    task automatic clear_all();
        for (int c = 0; c < NCH; c++) set_ch(c, 1'b0, 1'b0, '0, 1'b0, 4'd15, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        clear_all();
        rst = 1'b1;
        tick_all("rst_pulse", 4'd0);
        rst = 1'b0;
    endtask

    // Reference model state for the randomized phase.
    int m_cnt[NCH];
    bit m_ovf[NCH];

    initial begin
        // Reset held 3 cycles with all channels enabled.
        clear_all();
        en  = '1;
        rst = 1'b1;
        repeat (3) tick_all("reset_hold", 4'd0);
        rst = 1'b0;
        tick_all("post_reset_1", 4'd1);
        tick_all("post_reset_2", 4'd2);
        tick_all("post_reset_3", 4'd3);

        // Wrap up on ch0, limit 5.
        do_reset();
        set_ch(0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 1'b0, 1'b0);
        tick_ch("wrap_up", 0, 4'd1, 1'b0, 1'b0, 1'b0);
        tick_ch("wrap_up", 0, 4'd2, 1'b0, 1'b0, 1'b0);
        tick_ch("wrap_up", 0, 4'd3, 1'b0, 1'b0, 1'b0);
        tick_ch("wrap_up", 0, 4'd4, 1'b0, 1'b0, 1'b0);
        tick_ch("wrap_up_tc", 0, 4'd5, 1'b0, 1'b0, 1'b1);
        tick_ch("wrap_up_evt", 0, 4'd0, 1'b1, 1'b1, 1'b0);
        tick_ch("wrap_up_after", 0, 4'd1, 1'b0, 1'b1, 1'b0);
        en[0] = 1'b0;
        tick_ch("wrap_up_hold", 0, 4'd1, 1'b0, 1'b1, 1'b0);

        // Saturate down on ch1, limit 9, loaded with 2.
        do_reset();
        set_ch(1, 1'b0, 1'b1, 4'd2, 1'b1, 4'd9, 1'b1, 1'b0);
        tick_ch("sat_load", 1, 4'd2, 1'b0, 1'b0, 1'b0);
        set_ch(1, 1'b1, 1'b0, 4'd2, 1'b1, 4'd9, 1'b1, 1'b0);
        tick_ch("sat_down", 1, 4'd1, 1'b0, 1'b0, 1'b0);
        tick_ch("sat_down_zero", 1, 4'd0, 1'b0, 1'b0, 1'b1);
        tick_ch("sat_down_evt1", 1, 4'd0, 1'b1, 1'b1, 1'b1);
        tick_ch("sat_down_evt2", 1, 4'd0, 1'b1, 1'b1, 1'b1);
        en[1] = 1'b0;
        ovf_clr[1] = 1'b1;
        tick_ch("ovf_clear", 1, 4'd0, 1'b0, 1'b0, 1'b1);
        en[1] = 1'b1;
        tick_ch("ovf_clr_vs_evt", 1, 4'd0, 1'b1, 1'b1, 1'b1);
        en[1] = 1'b0;
        ovf_clr[1] = 1'b0;
        tick_ch("ovf_keep", 1, 4'd0, 1'b0, 1'b1, 1'b1);

        // Load priority over enable, and clamp to limit, on ch2.
        do_reset();
        set_ch(2, 1'b1, 1'b1, 4'd12, 1'b0, 4'd7, 1'b0, 1'b0);
        tick_ch("load_clamp", 2, 4'd7, 1'b0, 1'b0, 1'b1);
        load_en[2] = 1'b0;
        tick_ch("load_then_wrap", 2, 4'd0, 1'b1, 1'b1, 1'b0);
        en[2] = 1'b0;
        tick_ch("load_hold", 2, 4'd0, 1'b0, 1'b1, 1'b0);

        // Lowered limit and limit=0 on ch3.
        do_reset();
        set_ch(3, 1'b0, 1'b1, 4'd10, 1'b0, 4'd15, 1'b0, 1'b0);
        tick_ch("low_lim_load", 3, 4'd10, 1'b0, 1'b0, 1'b0);
        set_ch(3, 1'b1, 1'b0, 4'd0, 1'b1, 4'd4, 1'b0, 1'b0);
        tick_ch("low_lim_down", 3, 4'd4, 1'b0, 1'b0, 1'b0);
        down[3] = 1'b0;
        tick_ch("low_lim_up_wrap", 3, 4'd0, 1'b1, 1'b1, 1'b0);
        limit[3*W +: W] = 4'd0;
        tick_ch("lim0_wrap_a", 3, 4'd0, 1'b1, 1'b1, 1'b1);
        tick_ch("lim0_wrap_b", 3, 4'd0, 1'b1, 1'b1, 1'b1);
        sat_mode[3] = 1'b1;
        tick_ch("lim0_sat_up", 3, 4'd0, 1'b1, 1'b1, 1'b1);
        down[3] = 1'b1;
        tick_ch("lim0_sat_down", 3, 4'd0, 1'b1, 1'b1, 1'b1);

        // Randomized independence run against a reference model.
        do_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0;
            m_ovf[c] = 1'b0;
        end
        for (int cyc = 0; cyc < 1000; cyc++) begin
            exp_t e;
            rst = (cyc == 500);
            for (int c = 0; c < NCH; c++) begin
                set_ch(c, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                       W'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
                       W'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
                       ($urandom_range(0, 7) == 0));
            end
            e.name = "random";
            e.mask = '1;
            for (int c = 0; c < NCH; c++) begin
                int  lim;
                int  nxt;
                bit  ev;
                lim = int'(limit[c*W +: W]);
                nxt = m_cnt[c];
                ev  = 1'b0;
                if (rst) begin
                    nxt = 0;
                    m_ovf[c] = 1'b0;
                end else begin
                    if (load_en[c]) begin
                        nxt = (int'(load[c*W +: W]) < lim) ? int'(load[c*W +: W]) : lim;
                    end else if (en[c] && !down[c]) begin
                        if (m_cnt[c] < lim) nxt = m_cnt[c] + 1;
                        else begin
                            ev  = 1'b1;
                            nxt = sat_mode[c] ? lim : 0;
                        end
                    end else if (en[c]) begin
                        if (m_cnt[c] == 0) begin
                            ev  = 1'b1;
                            nxt = sat_mode[c] ? 0 : lim;
                        end else if (m_cnt[c] > lim) nxt = lim;
                        else nxt = m_cnt[c] - 1;
                    end
                    if (ev) m_ovf[c] = 1'b1;
                    else if (ovf_clr[c]) m_ovf[c] = 1'b0;
                end
                m_cnt[c]        = nxt;
                e.cnt[c*W +: W] = W'(nxt);
                e.evt[c]        = ev;
                e.ovf[c]        = m_ovf[c];
                e.tc[c]         = down[c] ? (nxt == 0) : (nxt >= lim);
            end
            push_tick(e);
        end
        rst = 1'b0;
        clear_all();

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
